// File: rtl/cwdma_pkg.sv
//==============================================================================
// Module   : cwdma_pkg
// Brief    : Shared constants and helpers for the CONV weight-DMA address path.
// Revision : 1.0 - initial 3-D address generator release
//==============================================================================
`default_nettype none

package cwdma_pkg;

    localparam int AW_DEF = 11;
    localparam int SW_DEF = 4;
    localparam int RW_DEF = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Callers zero-extend into 32 bits so one helper serves every counter width.
    function automatic logic cnt_at_limit(input logic [31:0] cnt, input logic [31:0] limit);
        return cnt == limit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dma_loop_cnt.sv
//==============================================================================
// Module   : dma_loop_cnt
// Brief    : Wrap-around loop counter; returns to zero on the step after limit.
// Revision : 1.0 - initial 3-D address generator release
//==============================================================================
`default_nettype none

module dma_loop_cnt
    import cwdma_pkg::*;
#(
    parameter int W = SW_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         at_limit
);

    logic [W-1:0] r_cnt;

    assign cnt      = r_cnt;
    assign at_limit = cnt_at_limit(32'(r_cnt), 32'(limit));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= at_limit ? '0 : r_cnt + W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/dma_dim3_agen.sv
//==============================================================================
// Module   : dma_dim3_agen
// Brief    : 3-D strided address stream generator with replay and first/last framing.
// Revision : 1.0 - initial 3-D address generator release
//==============================================================================
`default_nettype none

module dma_dim3_agen
    import cwdma_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int SW = SW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] cfg_base,
    input  logic [SW-1:0] cfg_dim0_size,
    input  logic [SW-1:0] cfg_dim0_step,
    input  logic [SW-1:0] cfg_dim1_size,
    input  logic [SW-1:0] cfg_dim1_step,
    input  logic [SW-1:0] cfg_dim2_size,
    input  logic [SW-1:0] cfg_dim2_step,
    input  logic [RW-1:0] cfg_repeat,
    input  logic          start_valid,
    output logic          start_ready,
    output logic [AW-1:0] s_addr,
    output logic          s_first,
    output logic          s_last,
    output logic          s_valid,
    input  logic          s_ready,
    output logic          busy
);

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;

    logic [AW-1:0] r_base;
    logic [SW-1:0] r_size [3];
    logic [SW-1:0] r_step [3];
    logic [RW-1:0] r_repeat;

    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_p1;
    logic [AW-1:0] r_p2;
    logic [AW-1:0] w_addr_nxt;
    logic [AW-1:0] w_p1_nxt;
    logic [AW-1:0] w_p2_nxt;

    logic [2:0]    w_inc;
    logic [2:0]    w_at;
    logic [SW-1:0] w_cnt [3];
    logic          w_rep_inc;
    logic          w_rep_at;
    logic [RW-1:0] w_rep_cnt;

    logic          w_run;
    logic          w_start_fire;
    logic          w_fire;
    logic          w_last;
    logic          w_all_zero;
    logic [AW-1:0] w_step0_ext;
    logic [AW-1:0] w_p1_step;
    logic [AW-1:0] w_p2_step;

    assign w_run        = (r_state == ST_RUN);
    assign start_ready  = (r_state == ST_IDLE) && !rst;
    assign w_start_fire = start_valid && start_ready;
    assign w_fire       = w_run && s_ready;

    assign w_last     = (&w_at) && w_rep_at;
    assign w_all_zero = (w_cnt[0] == '0) && (w_cnt[1] == '0) && (w_cnt[2] == '0) && (w_rep_cnt == '0);

    assign s_valid = w_run;
    assign busy    = w_run;
    assign s_addr  = r_addr;
    assign s_first = w_run && w_all_zero;
    assign s_last  = w_run && w_last;

    // Steps are unsigned offsets; every sum is truncated back to AW bits.
    assign w_step0_ext = AW'(r_step[0]);
    assign w_p1_step   = r_p1 + AW'(r_step[1]);
    assign w_p2_step   = r_p2 + AW'(r_step[2]);

    // Each dimension advances when every inner dimension wraps on the same fire.
    assign w_inc[0]  = w_fire;
    assign w_inc[1]  = w_fire && w_at[0];
    assign w_inc[2]  = w_fire && w_at[0] && w_at[1];
    assign w_rep_inc = w_fire && (&w_at);

    for (genvar k = 0; k < 3; k++) begin : g_dim
        dma_loop_cnt #(
            .W        (SW)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .clr      (w_start_fire),
            .inc      (w_inc[k]),
            .limit    (r_size[k]),
            .cnt      (w_cnt[k]),
            .at_limit (w_at[k])
        );
    end

    dma_loop_cnt #(
        .W        (RW)
    ) u_rep_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_start_fire),
        .inc      (w_rep_inc),
        .limit    (r_repeat),
        .cnt      (w_rep_cnt),
        .at_limit (w_rep_at)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start_fire)     w_state_nxt = ST_RUN;
            ST_RUN:  if (w_fire && w_last) w_state_nxt = ST_IDLE;
            default:                       w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Row pointers let each outer step restart from a running sum instead of a product.
    always_comb begin
        w_addr_nxt = r_addr;
        w_p1_nxt   = r_p1;
        w_p2_nxt   = r_p2;
        if (w_start_fire) begin
            w_addr_nxt = cfg_base;
            w_p1_nxt   = cfg_base;
            w_p2_nxt   = cfg_base;
        end else if (w_fire) begin
            if (!w_at[0]) begin
                w_addr_nxt = r_addr + w_step0_ext;
            end else if (!w_at[1]) begin
                w_p1_nxt   = w_p1_step;
                w_addr_nxt = w_p1_step;
            end else if (!w_at[2]) begin
                w_p2_nxt   = w_p2_step;
                w_p1_nxt   = w_p2_step;
                w_addr_nxt = w_p2_step;
            end else begin
                w_p2_nxt   = r_base;
                w_p1_nxt   = r_base;
                w_addr_nxt = r_base;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_p1   <= '0;
            r_p2   <= '0;
        end else begin
            r_addr <= w_addr_nxt;
            r_p1   <= w_p1_nxt;
            r_p2   <= w_p2_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base   <= '0;
            r_repeat <= '0;
            for (int k = 0; k < 3; k++) begin
                r_size[k] <= '0;
                r_step[k] <= '0;
            end
        end else if (w_start_fire) begin
            r_base    <= cfg_base;
            r_repeat  <= cfg_repeat;
            r_size[0] <= cfg_dim0_size;
            r_step[0] <= cfg_dim0_step;
            r_size[1] <= cfg_dim1_size;
            r_step[1] <= cfg_dim1_step;
            r_size[2] <= cfg_dim2_size;
            r_step[2] <= cfg_dim2_step;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dma_dim3_agen.sv
//==============================================================================
// Module   : tb_dma_dim3_agen
// Brief    : Self-checking bench: nested-loop reference model plus directed jobs.
// Revision : 1.0 - initial 3-D address generator release
//==============================================================================
`default_nettype none

module tb_dma_dim3_agen;

    logic        clk;
    logic        rst;
    logic [10:0] cfg_base;
    logic [3:0]  cfg_dim0_size, cfg_dim0_step;
    logic [3:0]  cfg_dim1_size, cfg_dim1_step;
    logic [3:0]  cfg_dim2_size, cfg_dim2_step;
    logic [15:0] cfg_repeat;
    logic        start_valid;
    logic        start_ready;
    logic [10:0] s_addr;
    logic        s_first;
    logic        s_last;
    logic        s_valid;
    logic        s_ready;
    logic        busy;

    dma_dim3_agen #(
        .AW (11),
        .SW (4),
        .RW (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_base      (cfg_base),
        .cfg_dim0_size (cfg_dim0_size),
        .cfg_dim0_step (cfg_dim0_step),
        .cfg_dim1_size (cfg_dim1_size),
        .cfg_dim1_step (cfg_dim1_step),
        .cfg_dim2_size (cfg_dim2_size),
        .cfg_dim2_step (cfg_dim2_step),
        .cfg_repeat    (cfg_repeat),
        .start_valid   (start_valid),
        .start_ready   (start_ready),
        .s_addr        (s_addr),
        .s_first       (s_first),
        .s_last        (s_last),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .busy          (busy)
    );

    typedef struct {
        logic [10:0] addr;
        logic        first;
        logic        last;
    } item_t;

    item_t       exp_q[$];
    logic [10:0] log_q[$];
    logic [10:0] lit_q[$];

    int   n_cmp = 0;
    int   n_err = 0;
    int   acc_cnt = 0;
    int   n_first = 0;
    int   n_last = 0;
    logic m_busy = 1'b0;
    logic chk_en = 1'b0;
    logic rdy_rand = 1'b0;
    logic prev_stall = 1'b0;
    logic [10:0] prev_addr;
    logic prev_first, prev_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: address = base + i0*step0 + i1*step1 + i2*step2 mod 2^11, replayed.
    task automatic gen_job();
        int    total;
        int    n;
        int    a_int;
        item_t it;
        total = (int'(cfg_dim0_size) + 1) * (int'(cfg_dim1_size) + 1) *
                (int'(cfg_dim2_size) + 1) * (int'(cfg_repeat) + 1);
        n = 0;
        for (int r = 0; r <= int'(cfg_repeat); r++)
            for (int c = 0; c <= int'(cfg_dim2_size); c++)
                for (int b = 0; b <= int'(cfg_dim1_size); b++)
                    for (int a = 0; a <= int'(cfg_dim0_size); a++) begin
                        a_int = int'(cfg_base) + a * int'(cfg_dim0_step) +
                                b * int'(cfg_dim1_step) + c * int'(cfg_dim2_step);
                        it.addr  = 11'(a_int % 2048);
                        it.first = (n == 0);
                        it.last  = (n == total - 1);
                        exp_q.push_back(it);
                        n++;
                    end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("start_ready", 32'(start_ready), 32'(!rst && !m_busy));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("s_valid", 32'(s_valid), 32'(m_busy));
            if (s_valid && m_busy) begin
                if (exp_q.size() == 0) begin
                    chk("queue_underflow", 32'(1), 32'(0));
                end else begin
                    chk("s_addr", 32'(s_addr), 32'(exp_q[0].addr));
                    chk("s_first", 32'(s_first), 32'(exp_q[0].first));
                    chk("s_last", 32'(s_last), 32'(exp_q[0].last));
                end
                if (prev_stall) begin
                    chk("hold_addr", 32'(s_addr), 32'(prev_addr));
                    chk("hold_first", 32'(s_first), 32'(prev_first));
                    chk("hold_last", 32'(s_last), 32'(prev_last));
                end
            end
            if (rst) begin
                exp_q.delete();
                m_busy     = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (s_valid && s_ready && m_busy && exp_q.size() > 0) begin
                    log_q.push_back(s_addr);
                    if (s_first) n_first++;
                    if (s_last)  n_last++;
                    if (exp_q[0].last) m_busy = 1'b0;
                    void'(exp_q.pop_front());
                end
                if (start_valid && start_ready) begin
                    gen_job();
                    m_busy = 1'b1;
                    acc_cnt++;
                end
                prev_stall = s_valid && !s_ready;
                prev_addr  = s_addr;
                prev_first = s_first;
                prev_last  = s_last;
            end
        end
    end

    initial begin
        s_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            s_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic set_cfg(input logic [10:0] base, input logic [3:0] s0, input logic [3:0] t0,
                           input logic [3:0] s1, input logic [3:0] t1, input logic [3:0] s2,
                           input logic [3:0] t2, input logic [15:0] rep);
        cfg_base      = base;
        cfg_dim0_size = s0;
        cfg_dim0_step = t0;
        cfg_dim1_size = s1;
        cfg_dim1_step = t1;
        cfg_dim2_size = s2;
        cfg_dim2_step = t2;
        cfg_repeat    = rep;
    endtask

    task automatic wait_accept(input string nm);
        int  old;
        logic ok;
        old = acc_cnt;
        ok  = 1'b0;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(posedge clk);
            #1;
            if (acc_cnt != old) ok = 1'b1;
        end
        start_valid = 1'b0;
        if (!ok) chk({nm, " accept_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic wait_idle(input string nm);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            if (!m_busy && exp_q.size() == 0) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) chk({nm, " idle_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic check_log(input string nm);
        chk({nm, " count"}, 32'(log_q.size()), 32'(lit_q.size()));
        for (int k = 0; k < lit_q.size() && k < log_q.size(); k++)
            chk(nm, 32'(log_q[k]), 32'(lit_q[k]));
    endtask

    task automatic run_job(input string nm);
        log_q.delete();
        n_first = 0;
        n_last  = 0;
        start_valid = 1'b1;
        wait_accept(nm);
        wait_idle(nm);
    endtask

    initial begin
        rst         = 1'b1;
        start_valid = 1'b0;
        set_cfg(11'h0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst s_valid", 32'(s_valid), 32'(0));
        chk("rst s_addr", 32'(s_addr), 32'(0));
        chk("rst s_first", 32'(s_first), 32'(0));
        chk("rst s_last", 32'(s_last), 32'(0));
        chk("rst busy", 32'(busy), 32'(0));
        chk("rst start_ready", 32'(start_ready), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst start_ready", 32'(start_ready), 32'(1));
        @(posedge clk);
        #1;

        // Basic 2-D job
        set_cfg(11'h010, 4'd2, 4'd1, 4'd1, 4'd4, 4'd0, 4'd0, 16'd0);
        run_job("job2d");
        lit_q = '{11'h010, 11'h011, 11'h012, 11'h014, 11'h015, 11'h016};
        check_log("job2d");
        chk("job2d firsts", 32'(n_first), 32'(1));
        chk("job2d lasts", 32'(n_last), 32'(1));

        // 3-D job
        set_cfg(11'h000, 4'd1, 4'd1, 4'd1, 4'd2, 4'd1, 4'd8, 16'd0);
        run_job("job3d");
        lit_q = '{11'h000, 11'h001, 11'h002, 11'h003, 11'h008, 11'h009, 11'h00A, 11'h00B};
        check_log("job3d");

        // Address wrap at 2^11
        set_cfg(11'h7FE, 4'd3, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 16'd0);
        run_job("wrap");
        lit_q = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        check_log("wrap");

        // Replay under random backpressure
        rdy_rand = 1'b1;
        set_cfg(11'h020, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 16'd1);
        run_job("repeat");
        rdy_rand = 1'b0;
        lit_q = '{11'h020, 11'h021, 11'h020, 11'h021};
        check_log("repeat");
        chk("repeat firsts", 32'(n_first), 32'(1));
        chk("repeat lasts", 32'(n_last), 32'(1));

        // Larger mixed job with backpressure, model-checked only
        rdy_rand = 1'b1;
        set_cfg(11'h7F0, 4'd2, 4'd3, 4'd2, 4'd15, 4'd1, 4'd9, 16'd2);
        run_job("mixed");
        rdy_rand = 1'b0;
        chk("mixed count", 32'(log_q.size()), 32'(54));

        // Second start held while busy
        log_q.delete();
        set_cfg(11'h010, 4'd2, 4'd1, 4'd1, 4'd4, 4'd0, 4'd0, 16'd0);
        start_valid = 1'b1;
        wait_accept("busyA");
        set_cfg(11'h100, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 16'd0);
        start_valid = 1'b1;
        wait_accept("busyB");
        chk("busyB accepted after", 32'(log_q.size()), 32'(6));
        wait_idle("busyB");
        lit_q = '{11'h010, 11'h011, 11'h012, 11'h014, 11'h015, 11'h016, 11'h100, 11'h102};
        check_log("busy_pair");

        // Reset after the third fire
        log_q.delete();
        set_cfg(11'h010, 4'd2, 4'd1, 4'd1, 4'd4, 4'd0, 4'd0, 16'd0);
        start_valid = 1'b1;
        wait_accept("rstjob");
        begin
            logic ok;
            ok = 1'b0;
            for (int k = 0; k < 100 && !ok; k++) begin
                if (log_q.size() >= 3) ok = 1'b1;
                else begin
                    @(posedge clk);
                    #1;
                end
            end
            if (!ok) chk("rstjob fire_timeout", 32'(0), 32'(1));
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst s_valid", 32'(s_valid), 32'(0));
        chk("midrst busy", 32'(busy), 32'(0));
        chk("midrst start_ready", 32'(start_ready), 32'(0));
        chk("midrst fires", 32'(log_q.size()), 32'(3));
        rst = 1'b0;
        @(negedge clk);
        chk("midrst release start_ready", 32'(start_ready), 32'(1));
        @(posedge clk);
        #1;

        // Recovery job after reset
        set_cfg(11'h7FE, 4'd3, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 16'd0);
        run_job("recover");
        lit_q = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        check_log("recover");

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
